// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and default widths for the instruction/data memory port arbiter.
// The arbiter serialises fetch and load/store accesses onto one memory port.
package riscv_mem_pkg;

   localparam int DEF_ADDR_W = 32;
   localparam int DEF_DATA_W = 32;

   typedef enum logic [2:0] {
      IDLE,
      GNT_IF,
      GNT_DM,
      RESP_IF,
      RESP_DM
   } arb_state_e;

   typedef enum logic [1:0] {
      GNT_NONE,
      GNT_FETCH,
      GNT_DATA
   } grant_e;

endpackage

// File: rtl/mem_port_arbiter_prio.sv
// Combinational priority pick: data wins unless a waiting fetch has already
// been passed over MAX_DM_STREAK times in a row.
module mem_arb_prio
   import riscv_mem_pkg::*;
#(
   parameter int MAX_DM_STREAK = 2,
   localparam int STREAK_W     = $clog2(MAX_DM_STREAK + 1)
) (
   input  logic                if_req,
   input  logic                dm_req,
   input  logic [STREAK_W-1:0] streak_i,
   output grant_e              grant_o,
   output logic [STREAK_W-1:0] streak_d_o
);

   logic streak_full;

   assign streak_full = (streak_i == STREAK_W'(MAX_DM_STREAK));

   always_comb begin
      grant_o    = GNT_NONE;
      streak_d_o = streak_i;
      if (dm_req && (!if_req || !streak_full)) begin
         grant_o = GNT_DATA;
         // The streak only counts data grants that made a fetch wait.
         if (!if_req)
            streak_d_o = '0;
         else if (!streak_full)
            streak_d_o = streak_i + STREAK_W'(1);
      end else if (if_req) begin
         grant_o    = GNT_FETCH;
         streak_d_o = '0;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single memory port shared by fetch and load/store; one access per 3 cycles
// minimum, with a pipeline stall while either requester is outstanding.
module mem_port_arbiter
   import riscv_mem_pkg::*;
#(
   parameter int ADDR_W        = DEF_ADDR_W,
   parameter int DATA_W        = DEF_DATA_W,
   parameter int MAX_DM_STREAK = 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                if_req,
   input  logic [ADDR_W-1:0]   if_addr,
   output logic [DATA_W-1:0]   if_rdata,
   output logic                if_ack,
   input  logic                dm_req,
   input  logic                dm_we,
   input  logic [ADDR_W-1:0]   dm_addr,
   input  logic [DATA_W-1:0]   dm_wdata,
   input  logic [DATA_W/8-1:0] dm_be,
   output logic [DATA_W-1:0]   dm_rdata,
   output logic                dm_ack,
   output logic                mem_req,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_be,
   input  logic [DATA_W-1:0]   mem_rdata,
   input  logic                mem_ready,
   output logic                stall
);

   localparam int BE_W     = DATA_W / 8;
   localparam int STREAK_W = $clog2(MAX_DM_STREAK + 1);

   arb_state_e          state_q;
   grant_e              grant;
   logic [STREAK_W-1:0] streak_q;
   logic [STREAK_W-1:0] streak_d;
   logic                mem_req_q;
   logic                mem_we_q;
   logic [ADDR_W-1:0]   mem_addr_q;
   logic [DATA_W-1:0]   mem_wdata_q;
   logic [BE_W-1:0]     mem_be_q;
   logic [DATA_W-1:0]   if_rdata_q;
   logic [DATA_W-1:0]   dm_rdata_q;
   logic                if_ack_q;
   logic                dm_ack_q;

   mem_arb_prio #(
      .MAX_DM_STREAK (MAX_DM_STREAK)
   ) u_prio (
      .if_req     (if_req),
      .dm_req     (dm_req),
      .streak_i   (streak_q),
      .grant_o    (grant),
      .streak_d_o (streak_d)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         streak_q    <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_be_q    <= '0;
         if_rdata_q  <= '0;
         dm_rdata_q  <= '0;
         if_ack_q    <= 1'b0;
         dm_ack_q    <= 1'b0;
      end else begin
         if_ack_q <= 1'b0;
         dm_ack_q <= 1'b0;
         case (state_q)
            IDLE: begin
               streak_q <= streak_d;
               case (grant)
                  GNT_FETCH: begin
                     state_q     <= GNT_IF;
                     mem_req_q   <= 1'b1;
                     mem_we_q    <= 1'b0;
                     mem_addr_q  <= if_addr;
                     mem_wdata_q <= '0;
                     mem_be_q    <= '1;
                  end
                  GNT_DATA: begin
                     state_q     <= GNT_DM;
                     mem_req_q   <= 1'b1;
                     mem_we_q    <= dm_we;
                     mem_addr_q  <= dm_addr;
                     mem_wdata_q <= dm_wdata;
                     mem_be_q    <= dm_be;
                  end
                  default: state_q <= IDLE;
               endcase
            end
            GNT_IF: begin
               if (mem_ready) begin
                  state_q    <= RESP_IF;
                  mem_req_q  <= 1'b0;
                  if_rdata_q <= mem_rdata;
                  if_ack_q   <= 1'b1;
               end
            end
            GNT_DM: begin
               if (mem_ready) begin
                  state_q   <= RESP_DM;
                  mem_req_q <= 1'b0;
                  dm_ack_q  <= 1'b1;
                  // Stores complete without disturbing the last load result.
                  if (!mem_we_q)
                     dm_rdata_q <= mem_rdata;
               end
            end
            RESP_IF, RESP_DM: state_q <= IDLE;
            default:          state_q <= IDLE;
         endcase
      end
   end

   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_be    = mem_be_q;
   assign if_rdata  = if_rdata_q;
   assign dm_rdata  = dm_rdata_q;
   assign if_ack    = if_ack_q;
   assign dm_ack    = dm_ack_q;

   assign stall = !reset && ((if_req && !if_ack_q) || (dm_req && !dm_ack_q));

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-ported instruction/data memory between the core's instruction-fetch path and its load/store path. Sits between `riscv`'s datapath and the unified memory model. Serialises the two requesters with data-first priority and a starvation guard. Drives a `stall` to freeze the pipeline while any access is outstanding.

## Interface
Parameters:
- `ADDR_W`, 32: byte address width.
- `DATA_W`, 32: data width; byte-enable width is `DATA_W/8`.
- `MAX_DM_STREAK`, 2: maximum consecutive data grants while a fetch is waiting.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `reset`, in, 1: synchronous, active-high.
- `if_req`, in, 1: fetch request; held until `if_ack`.
- `if_addr`, in, `ADDR_W`: fetch address; stable while `if_req`.
- `if_rdata`, out, `DATA_W`: fetched word, registered.
- `if_ack`, out, 1: one-cycle completion pulse.
- `dm_req`, in, 1: load/store request; held until `dm_ack`.
- `dm_we`, in, 1: 1 = store.
- `dm_addr`, in, `ADDR_W`: data address.
- `dm_wdata`, in, `DATA_W`: store data.
- `dm_be`, in, `DATA_W/8`: byte enables.
- `dm_rdata`, out, `DATA_W`: load data, registered.
- `dm_ack`, out, 1: one-cycle completion pulse.
- `mem_req`, out, 1: memory access valid; held until `mem_ready`.
- `mem_we`, out, 1: memory write enable.
- `mem_addr`, out, `ADDR_W`: memory address.
- `mem_wdata`, out, `DATA_W`: memory write data.
- `mem_be`, out, `DATA_W/8`: memory byte enables.
- `mem_rdata`, in, `DATA_W`: memory read data; valid in the `mem_ready` cycle.
- `mem_ready`, in, 1: memory completion; sampled only while `mem_req`=1.
- `stall`, out, 1: pipeline freeze.

## Operation
- FSM states and transitions:
  - `IDLE`: arbitrate.
  - `IDLE` → `GNT_IF` or `GNT_DM` when a request is present.
  - `GNT_x`: wait for `mem_ready`, then → `RESP_x`.
  - `RESP_x`: pulse `x_ack`, then → `IDLE` unconditionally. No arbitration occurs in `RESP`.
- Arbitration, evaluated in `IDLE` only:
  - Only one requester: grant it.
  - Both requesting: grant `dm`, unless `streak == MAX_DM_STREAK`, in which case grant `if`.
  - Streak counter (width `$clog2(MAX_DM_STREAK+1)`):
    - increments on a `dm` grant while `if_req`=1, saturating;
    - clears on any `if` grant;
    - clears on a `dm` grant while `if_req`=0.
- On the grant edge, `mem_we/addr/wdata/be` are registered from the winner and `mem_req` is set. They hold constant through `GNT_x`.
  - Fetch grants drive `mem_we`=0 and `mem_be`=all ones.
- On `mem_ready` in `GNT_x`:
  - `mem_req` clears next cycle.
  - `mem_rdata` is latched into `x_rdata`, for reads only; stores leave `dm_rdata` unchanged.
- `if_rdata`/`dm_rdata` hold their value until the next read completion for that requester.
- `stall` = (`if_req` & ~`if_ack`) | (`dm_req` & ~`dm_ack`), combinational. Forced 0 while `reset`=1.
- Requesters must change or drop `req` on the edge following `ack`. A `req` still high in the cycle after `RESP` is treated as a new request.

## Timing
- Reset values, applied at the first clock edge with `reset`=1:
  - state `IDLE`, streak 0;
  - `mem_req`, `mem_we`, `if_ack`, `dm_ack` = 0;
  - `mem_addr`, `mem_wdata`, `mem_be`, `if_rdata`, `dm_rdata` = 0;
  - `stall` = 0.
- Minimum latency with `mem_ready` tied 1:
  - `req` seen in cycle 0 (`IDLE`);
  - `mem_req`=1 in cycle 1;
  - `ack` and `rdata` in cycle 2;
  - next arbitration in cycle 3.
  - Throughput is 1 access per 3 cycles.
- Each wait cycle of `mem_ready`=0 adds one cycle.
- `mem_ready` while `mem_req`=0 is ignored.
- Reset during `GNT_x` or `RESP_x`:
  - `mem_req` drops on the next edge;
  - no `ack` is issued;
  - the in-flight access is abandoned; the memory must tolerate request withdrawal.
- Simultaneous requests in `IDLE` are resolved by the arbitration rule in the same cycle. The loser's request stays pending, with no loss.
- Requests arriving during `GNT`/`RESP` wait for `IDLE`.

## Structure
- Package `riscv_mem_pkg`:
  - `arb_state_e` (`IDLE`, `GNT_IF`, `GNT_DM`, `RESP_IF`, `RESP_DM`);
  - `grant_e` (`GNT_NONE`, `GNT_FETCH`, `GNT_DATA`);
  - default `ADDR_W`/`DATA_W` constants.
- Sub-module `mem_arb_prio`:
  - inputs: `if_req`, `dm_req`, streak;
  - outputs: `grant_e` and the streak next-value;
  - combinational, unit-testable on its own.
- Top: FSM, request registers, response registers, `stall`.

## Test plan
- Single fetch, `mem_ready`=1, `if_addr`=0x10, `mem_rdata`=0x00500093 → `mem_req` in cycle 1; `if_ack` and `if_rdata`=0x00500093 in cycle 2; `stall`=1 in cycles 0–1 and 0 in cycle 2.
- Store, `dm_addr`=0x40, `dm_wdata`=0xDEADBEEF, `dm_be`=0xF, `mem_ready` delayed 3 cycles → `mem_we`=1 and `mem_wdata`=0xDEADBEEF stable for 4 cycles; `dm_ack` one cycle after `mem_ready`; `dm_rdata` unchanged.
- `if_req` and `dm_req` both held continuously, `MAX_DM_STREAK`=2 → grant order DM, DM, IF, DM, DM, IF.
- Both requests in the same cycle, streak 0 → DM granted first. IF is granted at the first `IDLE` after `dm_ack`, with `if_req` never dropped.
- `reset` asserted during `GNT_DM` with `mem_ready`=0 → next cycle `mem_req`=0, no `dm_ack`, all outputs 0.
- `mem_ready` pulsed while `IDLE` → ignored: no ack, state stays `IDLE`.
